// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution result RAM.
//   ram_wr_state_t        : write-side controller states
//   RESULT_DATA_WIDTH     : default result sample width
//   RESULT_ADDRESS_WIDTH  : default result RAM address width
package conv_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, WRITE, DONE} ram_wr_state_t;

  localparam int RESULT_DATA_WIDTH    = 16;
  localparam int RESULT_ADDRESS_WIDTH = 5;

endpackage

// File: rtl/ram_sync_sp.sv
// Single-clock RAM: one write port and one registered read port.
// The read timing matches the coefficient/sample ROMs: 1-cycle latency.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset (zeroes rd_data only, not the array)
//   we      write enable
//   waddr   write address
//   wdata   write data
//   raddr   read address
//   rd_data registered read data
module ram_sync_sp
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = RESULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = RESULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking update of mem means a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[raddr];
    end
  end

endmodule

// File: rtl/conv_result_ram.sv
// Captures one frame of LENGTH convolution results into a synchronous RAM
// at addresses 0..LENGTH-1, then holds them for readout through a
// registered 1-cycle read port.
// Optional feature: define CONV_RESULT_RAM_CLEAR_EN to zero the whole RAM
// (one word per cycle) after each accepted start, before writing begins.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             pulse that begins a frame (ignored while busy)
//   din, din_valid    result stream input
//   din_ready         high while the block accepts samples
//   busy              frame in progress (clearing or writing)
//   done              frame complete, held until the next accepted start
//   wr_count          samples written in the current or last frame
//   rd_address        readout address
//   rd_data           registered read data, 1-cycle latency
// Handshake: a sample is taken on a rising edge where din_valid && din_ready;
// din_ready depends only on controller state, never on din_valid.
module conv_result_ram
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = RESULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = RESULT_ADDRESS_WIDTH,
  parameter int LENGTH        = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   wr_count,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LAST_COUNT = (ADDRESS_WIDTH + 1)'(LENGTH);

  if (LENGTH < 1 || LENGTH > DEPTH) begin : g_bad_length
    $error("conv_result_ram: LENGTH must be in 1..2**ADDRESS_WIDTH");
  end

  ram_wr_state_t state;
  ram_wr_state_t next_state;

  logic                     handshake;
  logic                     last_sample;
  logic                     start_ok;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;

  assign handshake   = (state == WRITE) && din_valid;
  assign last_sample = handshake && ((wr_count + 1'b1) == LAST_COUNT);
  assign start_ok    = start && ((state == IDLE) || (state == DONE));

  assign din_ready = (state == WRITE);
  assign busy      = (state == WRITE) || (state == CLEAR);
  assign done      = (state == DONE);

`ifdef CONV_RESULT_RAM_CLEAR_EN
  logic [ADDRESS_WIDTH-1:0] clr_count;
  logic                     clr_last;

  assign clr_last = &clr_count;

  always_ff @(posedge clk) begin
    if (!rst_n || state != CLEAR) begin
      clr_count <= '0;
    end else begin
      clr_count <= clr_count + 1'b1;
    end
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef CONV_RESULT_RAM_CLEAR_EN
          next_state = CLEAR;
`else
          next_state = WRITE;
`endif
        end
      end
      CLEAR: begin
`ifdef CONV_RESULT_RAM_CLEAR_EN
        if (clr_last) begin
          next_state = WRITE;
        end
`else
        next_state = IDLE;
`endif
      end
      WRITE: begin
        if (last_sample) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_count <= '0;
    end else begin
      state <= next_state;
      if (start_ok) begin
        wr_count <= '0;
      end else if (handshake) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // Write port mux: clear sweep has priority; reset blocks any write.
  always_comb begin
    we    = rst_n && handshake;
    waddr = wr_count[ADDRESS_WIDTH-1:0];
    wdata = din;
`ifdef CONV_RESULT_RAM_CLEAR_EN
    if (state == CLEAR) begin
      we    = rst_n;
      waddr = clr_count;
      wdata = '0;
    end
`endif
  end

  ram_sync_sp #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (rd_address),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_conv_result_ram.sv
// Self-checking bench for conv_result_ram. A frame-level reference model
// (array of words plus frame flags) predicts every output each cycle.
// Honours CONV_RESULT_RAM_CLEAR_EN when defined for both DUT and model.
module tb_conv_result_ram;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int LEN   = 20;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_data;

  conv_result_ram #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .LENGTH       (LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .rd_address(rd_address),
    .rd_data   (rd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_writing;
  bit            m_finished;
  int            m_clear_left;
  int            m_count;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            known_q[$];
  int            checks;
  int            errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // then compare every DUT output after the edge.
  task automatic tick();
    logic [DW-1:0] e_rd;
    bit            e_known;
    if (!rst_n) begin
      m_writing    = 0;
      m_finished   = 0;
      m_clear_left = 0;
      m_count      = 0;
      e_rd         = '0;
      e_known      = 1;
    end else begin
      e_rd    = m_mem[rd_address];
      e_known = m_known[rd_address];
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left]   = '0;
        m_known[DEPTH - m_clear_left] = 1;
        m_clear_left--;
        if (m_clear_left == 0) m_writing = 1;
      end else if (m_writing) begin
        if (din_valid) begin
          m_mem[m_count]   = din;
          m_known[m_count] = 1;
          m_count++;
          if (m_count == LEN) begin
            m_writing  = 0;
            m_finished = 1;
          end
        end
      end else if (start) begin
        m_count    = 0;
        m_finished = 0;
`ifdef CONV_RESULT_RAM_CLEAR_EN
        m_clear_left = DEPTH;
`else
        m_writing = 1;
`endif
      end
    end
    exp_q.push_back(e_rd);
    known_q.push_back(e_known);
    @(posedge clk);
    #1;
    e_rd    = exp_q.pop_front();
    e_known = known_q.pop_front();
    if (e_known) check_val("rd_data", 32'(rd_data), 32'(e_rd));
    check_val("busy", 32'(busy), 32'(m_writing || (m_clear_left > 0)));
    check_val("done", 32'(done), 32'(m_finished));
    check_val("din_ready", 32'(din_ready), 32'(m_writing));
    check_val("wr_count", 32'(wr_count), 32'(m_count));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input bit v, input logic [DW-1:0] d, input logic [AW-1:0] ra);
    start      = s;
    din_valid  = v;
    din        = d;
    rd_address = ra;
    tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(0, 0, '0, AW'($urandom_range(0, DEPTH - 1)));
    rst_n = 1'b1;
  endtask

  // Accepted start; with the clear sweep enabled also runs the sweep out.
  task automatic start_frame();
    drive(1, 0, '0, '0);
`ifdef CONV_RESULT_RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 16'hFFFF, AW'(i));
`endif
  endtask

  task automatic read_all(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, AW'(i));
    drive(0, 0, '0, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    checks       = 0;
    errors       = 0;
    m_writing    = 0;
    m_finished   = 0;
    m_clear_left = 0;
    m_count      = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 0;
    end
    rst_n      = 1'b0;
    start      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    rd_address = '0;

    do_reset(2);

    // back-to-back frame 0x0001..0x0014, then read it back
    start_frame();
    for (int i = 0; i < LEN; i++) drive(0, 1, DW'(i + 1), AW'($urandom_range(0, DEPTH - 1)));
    read_all(LEN);

    // stalled frame: valid every other cycle
    start_frame();
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      drive(0, (i % 2) == 0, DW'(i / 2 + 1), AW'(i % DEPTH));
      lat++;
      if (done) break;
    end
    check_val("stall_latency", 32'(lat), 32'd39);
    read_all(LEN);

    // start pulsed mid-frame is ignored
    start_frame();
    for (int i = 0; i < 7; i++) drive(0, 1, DW'($urandom), '0);
    drive(1, 1, DW'($urandom), '0);
    for (int i = 8; i < LEN; i++) drive(0, 1, DW'($urandom), AW'(i));
    read_all(LEN);

    // reset after 5 samples, then same-address read/write collision
    start_frame();
    for (int i = 0; i < 5; i++) drive(0, 1, DW'(16'h0A00 + i), '0);
    do_reset(1);
    read_all(5);
    start_frame();
    for (int i = 0; i < 3; i++) drive(0, 1, DW'($urandom), 5'd3);
    drive(0, 1, 16'hBEEF, 5'd3);
    drive(0, 0, 16'h0000, 5'd3);
    for (int i = 4; i < LEN; i++) drive(0, 1, DW'($urandom), AW'(i));

    // DONE ignores din_valid; next start clears done
    for (int i = 0; i < 10; i++) drive(0, 1, 16'hFFFF, AW'(i));
    read_all(LEN);
    drive(1, 1, 16'hFFFF, '0);
    drive(0, 0, '0, '0);

`ifdef CONV_RESULT_RAM_CLEAR_EN
    // finish the frame, then a clear sweep with din_valid held low
    for (int i = 0; i < 40 && !done; i++) drive(0, 1, DW'($urandom), '0);
    start_frame();
    read_all(DEPTH);
`endif

    // randomized traffic with occasional start and reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
              DW'($urandom), AW'($urandom_range(0, DEPTH - 1)));
      end
    end
    start = 1'b0;
    din_valid = 1'b0;
    read_all(DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
